// File: rtl/step_scheduler_pkg.sv
// Shared encodings for the step scheduler and its round-robin picker.
package step_scheduler_pkg;

  // Command in force during the current slot.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAN  = 2'd1,
    ST_AUTO = 2'd2
  } state_t;

  // Which requester won the most recent grant.
  typedef enum logic {
    GR_MAN  = 1'b0,
    GR_AUTO = 1'b1
  } grant_t;

  localparam logic DIR_UP = 1'b1;

endpackage

// File: rtl/step_scheduler_rr_pick2.sv
// Combinational two-requester round-robin picker. On a conflict the
// requester that did not win last time gets the grant.
module rr_pick2
  import step_scheduler_pkg::*;
(
  input  logic i_req_man,
  input  logic i_req_auto,
  input  logic i_last_grant,
  output logic o_gnt_man,
  output logic o_gnt_auto
);

  // Pick at most one requester; conflicts alternate.
  always_comb begin
    o_gnt_man  = 1'b0;
    o_gnt_auto = 1'b0;
    if (i_req_man && i_req_auto) begin
      if (grant_t'(i_last_grant) == GR_AUTO) o_gnt_man  = 1'b1;
      else                                   o_gnt_auto = 1'b1;
    end else if (i_req_man) begin
      o_gnt_man = 1'b1;
    end else if (i_req_auto) begin
      o_gnt_auto = 1'b1;
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// Step scheduler: arbitrates a manual single-step requester and a burst
// requester onto the counter's Up/Down lines, one command per Tick slot.
// Up and Down are never driven high together.
module step_scheduler
  import step_scheduler_pkg::*;
#(
  parameter int BURST_W = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Tick,
  input  logic               ManReq,
  input  logic               ManDir,
  output logic               ManAck,
  input  logic               AutoReq,
  input  logic               AutoDir,
  input  logic [BURST_W-1:0] AutoCount,
  input  logic               AutoAbort,
  output logic               AutoAck,
  output logic               AutoBusy,
  output logic               AutoDone,
  output logic               Up,
  output logic               Down
);

  state_t               r_state, w_state;
  grant_t               r_last, w_last;
  logic                 r_dir, w_dir;
  logic [BURST_W-1:0]   r_remaining, w_remaining;
  logic                 r_up, w_up;
  logic                 r_down, w_down;
  logic                 r_busy, w_busy;
  logic                 r_man_ack, w_man_ack;
  logic                 r_auto_ack, w_auto_ack;
  logic                 r_auto_done, w_auto_done;
  logic                 w_arb;
  logic                 w_gnt_man, w_gnt_auto;

  // Arbitration is open unless a burst still has steps left and no abort.
  assign w_arb = (r_state != ST_AUTO) || (r_remaining == '0) || AutoAbort;

  rr_pick2 u_pick (
    .i_req_man    (ManReq),
    .i_req_auto   (AutoReq),
    .i_last_grant (r_last),
    .o_gnt_man    (w_gnt_man),
    .o_gnt_auto   (w_gnt_auto)
  );

  // Next slot's command, state and handshake pulses.
  always_comb begin
    w_state     = r_state;
    w_last      = r_last;
    w_dir       = r_dir;
    w_remaining = r_remaining;
    w_up        = r_up;
    w_down      = r_down;
    w_busy      = r_busy;
    w_man_ack   = 1'b0;
    w_auto_ack  = 1'b0;
    w_auto_done = 1'b0;

    // Any slot boundary that reopens arbitration from AUTO ends the burst.
    if (r_state == ST_AUTO && w_arb) w_auto_done = 1'b1;

    if (w_arb) begin
      if (w_gnt_man) begin
        w_state   = ST_MAN;
        w_up      = (ManDir == DIR_UP);
        w_down    = (ManDir != DIR_UP);
        w_man_ack = 1'b1;
        w_last    = GR_MAN;
        w_busy    = 1'b0;
      end else if (w_gnt_auto) begin
        w_state    = ST_AUTO;
        w_busy     = 1'b1;
        w_auto_ack = 1'b1;
        w_last     = GR_AUTO;
        w_dir      = AutoDir;
        if (AutoCount != '0) begin
          w_up        = (AutoDir == DIR_UP);
          w_down      = (AutoDir != DIR_UP);
          w_remaining = AutoCount - 1'b1;
        end else begin
          // Zero-length burst still owns one empty slot.
          w_up        = 1'b0;
          w_down      = 1'b0;
          w_remaining = '0;
        end
      end else begin
        w_state = ST_IDLE;
        w_up    = 1'b0;
        w_down  = 1'b0;
        w_busy  = 1'b0;
      end
    end else begin
      // Burst continues in the direction latched at grant.
      w_up        = (r_dir == DIR_UP);
      w_down      = (r_dir != DIR_UP);
      w_remaining = r_remaining - 1'b1;
    end
  end

  // State and slot command advance only on Tick edges.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_last      <= GR_AUTO;
      r_dir       <= 1'b0;
      r_remaining <= '0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_busy      <= 1'b0;
    end else if (Tick) begin
      r_state     <= w_state;
      r_last      <= w_last;
      r_dir       <= w_dir;
      r_remaining <= w_remaining;
      r_up        <= w_up;
      r_down      <= w_down;
      r_busy      <= w_busy;
    end
  end

  // Handshake pulses: set on a Tick edge, cleared on the next Clock edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_man_ack   <= 1'b0;
      r_auto_ack  <= 1'b0;
      r_auto_done <= 1'b0;
    end else begin
      r_man_ack   <= Tick & w_man_ack;
      r_auto_ack  <= Tick & w_auto_ack;
      r_auto_done <= Tick & w_auto_done;
    end
  end

  assign Up       = r_up;
  assign Down     = r_down;
  assign AutoBusy = r_busy;
  assign ManAck   = r_man_ack;
  assign AutoAck  = r_auto_ack;
  assign AutoDone = r_auto_done;

endmodule

// File: tb/tb_step_scheduler.sv
// Scoreboard bench for step_scheduler: each Tick pushes the expected
// post-edge outputs {Up,Down,ManAck,AutoAck,AutoBusy,AutoDone}; a monitor
// pops and compares after every Tick edge and checks holds in between.
module tb_step_scheduler;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Tick = 1'b0;
  logic       ManReq = 1'b0, ManDir = 1'b0;
  logic       AutoReq = 1'b0, AutoDir = 1'b0, AutoAbort = 1'b0;
  logic [3:0] AutoCount = 4'd0;
  logic       ManAck, AutoAck, AutoBusy, AutoDone, Up, Down;

  int n_chk = 0;
  int n_fail = 0;
  logic [5:0] q[$];
  logic [5:0] hold = 6'b0;

  step_scheduler #(.BURST_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick),
    .ManReq(ManReq), .ManDir(ManDir), .ManAck(ManAck),
    .AutoReq(AutoReq), .AutoDir(AutoDir), .AutoCount(AutoCount),
    .AutoAbort(AutoAbort), .AutoAck(AutoAck), .AutoBusy(AutoBusy),
    .AutoDone(AutoDone), .Up(Up), .Down(Down)
  );

  always #5 Clock = ~Clock;

  function automatic logic [5:0] outs();
    return {Up, Down, ManAck, AutoAck, AutoBusy, AutoDone};
  endfunction

  task automatic check(input string name, input logic [5:0] act,
                       input logic [5:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (Up,Down,MAck,AAck,Busy,Done) t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Monitor: after a Tick edge compare against the scoreboard, otherwise
  // the command must hold and pulses must be low.
  logic t_s;
  logic [5:0] e;
  always @(posedge Clock) begin
    t_s = Tick;
    #1;
    if (t_s) begin
      if (q.size() == 0) begin
        check("tick_without_expectation", outs(), 6'bxxxxxx);
      end else begin
        e = q.pop_front();
        check("tick_edge", outs(), e);
        hold = e;
      end
    end else begin
      check("hold", outs(), {hold[5:4], 2'b00, hold[1], 1'b0});
    end
  end

  // Up and Down must never be high together.
  always @(Up or Down) begin
    n_chk++;
    assert (!(Up && Down)) else begin
      n_fail++;
      $display("FAIL updown_exclusive: Up=%b Down=%b t=%0t", Up, Down, $time);
    end
  end

  // One Tick slot; gap = extra non-Tick cycles after it.
  task automatic tick(input logic [5:0] exp, input int gap);
    @(negedge Clock);
    Tick = 1'b1;
    q.push_back(exp);
    @(negedge Clock);
    Tick = 1'b0;
    repeat (gap) @(negedge Clock);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    hold = 6'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, %0d expectations pending", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge Clock);
    check("reset_state", outs(), 6'b000000);
    Reset = 1'b0;

    // Manual single step up, request dropped after ack.
    ManReq = 1; ManDir = 1;
    tick(6'b101000, 2);
    ManReq = 0;
    tick(6'b000000, 2);
    tick(6'b000000, 2);

    // Down burst of 3.
    AutoReq = 1; AutoDir = 0; AutoCount = 3;
    tick(6'b010110, 2);
    AutoReq = 0; AutoDir = 1; AutoCount = 9;
    tick(6'b010010, 2);
    tick(6'b010010, 2);
    tick(6'b000001, 2);

    // Round-robin from reset exit, back-to-back Ticks.
    do_reset();
    ManReq = 1; ManDir = 0;
    AutoReq = 1; AutoDir = 1; AutoCount = 2;
    tick(6'b011000, 0);
    tick(6'b100110, 0);
    tick(6'b100010, 0);
    tick(6'b011001, 0);
    ManReq = 0; AutoReq = 0;
    tick(6'b000000, 2);

    // Count-5 burst aborted during slot 2.
    AutoReq = 1; AutoDir = 1; AutoCount = 5;
    tick(6'b100110, 2);
    AutoReq = 0;
    tick(6'b100010, 1);
    AutoAbort = 1;
    tick(6'b000001, 2);
    AutoAbort = 0;
    tick(6'b000000, 2);

    // Zero-length burst.
    AutoReq = 1; AutoDir = 1; AutoCount = 0;
    tick(6'b000110, 2);
    AutoReq = 0;
    tick(6'b000001, 2);

    // Burst end re-granted to a new burst in the same edge.
    AutoReq = 1; AutoDir = 0; AutoCount = 1;
    tick(6'b010110, 2);
    AutoDir = 1; AutoCount = 2;
    tick(6'b100111, 2);
    AutoReq = 0;
    tick(6'b100010, 2);
    tick(6'b000001, 2);

    // Reset with Remaining=2: outputs drop at once, no AutoDone later.
    AutoReq = 1; AutoDir = 0; AutoCount = 4;
    tick(6'b010110, 2);
    AutoReq = 0;
    tick(6'b010010, 1);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    hold = 6'b0;
    #1;
    check("async_reset_outputs", outs(), 6'b000000);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    tick(6'b000000, 2);
    AutoReq = 1; AutoDir = 1; AutoCount = 1;
    tick(6'b100110, 2);
    AutoReq = 0;
    tick(6'b000001, 2);
    tick(6'b000000, 3);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/step_scheduler.md
# step_scheduler

Command scheduler for the up/down counter state machine on the board. Two requesters share the counter's `Up`/`Down` command lines:
- a manual single-step requester driven from switches/keys;
- an automatic burst requester that asks for N consecutive steps in one direction.

The block arbitrates between them, issues at most one command per step slot, and guarantees `Up` and `Down` are never asserted together, so the counter's error state is never entered by accident. It sits between the frequency-divider tick and the counter, in the same `Clock` domain; the counter consumes a command on each `Tick` cycle.

## Interface
- `BURST_W`, 4, width of the burst step count.

- `Clock`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-high.
- `Tick`  in  1  one-`Clock`-cycle step enable from the divider. Slot boundary.
- `ManReq`  in  1  manual step request (level, held until `ManAck`).
- `ManDir`  in  1  manual direction: 1 = up, 0 = down.
- `ManAck`  out  1  one-cycle pulse; manual step loaded.
- `AutoReq`  in  1  burst request (level, held until `AutoAck`).
- `AutoDir`  in  1  burst direction: 1 = up, 0 = down.
- `AutoCount`  in  `BURST_W`  burst length in steps.
- `AutoAbort`  in  1  level; ends the running burst at the next `Tick` edge.
- `AutoAck`  out  1  one-cycle pulse; burst granted.
- `AutoBusy`  out  1  high while a burst owns the slots.
- `AutoDone`  out  1  one-cycle pulse; burst finished or aborted.
- `Up`  out  1  command to counter, constant for a whole slot.
- `Down`  out  1  command to counter, constant for a whole slot.

## Operation
- States:
  - `IDLE`: current slot carries no command.
  - `MAN`: current slot carries one manual step.
  - `AUTO`: current slot belongs to a burst.
- The state describes the command in force during the current slot.
- All state, output and handshake updates happen only on a "Tick edge": a `Clock` rising edge where `Tick == 1`. Between Tick edges everything holds.
- Reset values: state `IDLE`, `Up`=0, `Down`=0, `ManAck`=0, `AutoAck`=0, `AutoDone`=0, `AutoBusy`=0, `Remaining`=0, `LastGrant`=AUTO.
- Reset dominates `Tick`.
- Reset mid-burst or mid-slot: outputs drop to 0 asynchronously. No `AutoDone` is issued for the killed burst.
- Arbitration runs at a Tick edge when:
  - state is `IDLE` or `MAN`; or
  - state is `AUTO` with the burst ending (`Remaining == 0` or `AutoAbort == 1`).
- Arbitration results:
  - Only `ManReq`: go to `MAN`; load `Up`=`ManDir`, `Down`=!`ManDir`; pulse `ManAck`; `LastGrant`=MAN.
  - Only `AutoReq`: go to `AUTO`; `AutoBusy`=1; pulse `AutoAck`; `LastGrant`=AUTO.
    - `AutoCount` ≥ 1: load the first step from `AutoDir`; `Remaining` = `AutoCount` - 1.
    - `AutoCount` = 0: empty slot (`Up`=`Down`=0); `Remaining`=0.
  - Both: grant the requester that is not `LastGrant` (round-robin). The first conflict after reset goes to manual.
  - Neither: go to `IDLE`; `Up`=`Down`=0.
- `AUTO` Tick edge with `Remaining` > 0 and no abort: load the next step in the direction latched at grant; `Remaining` decrements.
- Burst end: pulse `AutoDone`; `AutoBusy`=0 unless the same edge re-grants AUTO.
- Bursts are non-preemptive. `ManReq` waits, except that `AutoAbort` shortens the burst.
- An already-loaded step is always consumed by the counter; abort never retracts it.
- `ManDir`, `AutoDir` and `AutoCount` are sampled only at the grant edge.
- A request dropped before its grant produces no ack.
- Invariant: `Up & Down` == 0 at all times.

## Timing
- Grant-to-command latency: 0. The command appears on the `Clock` edge after the Tick cycle that sampled the request, and the counter consumes it at the next `Tick`.
- Acks and `AutoDone` are registered, one `Clock` cycle wide, and coincident with the output change.
- A burst of N ≥ 1 steps occupies exactly N consecutive slots. `AutoDone` pulses at the Tick edge ending slot N.
- A count-0 burst occupies one empty slot.
- Back-to-back grants have no idle slot between them.
- `Tick` on consecutive `Clock` cycles is legal: each cycle is a full slot.

## Structure
- Shared package holds:
  - state encoding `IDLE`/`MAN`/`AUTO`;
  - grant encoding `MAN`/`AUTO` for `LastGrant`;
  - constant `DIR_UP` = 1.
- One sub-module, `rr_pick2`: a combinational two-requester round-robin picker taking the two requests and `LastGrant`, returning the grant. Everything else is flat in `step_scheduler`.

## Test plan
- Reset, then `ManReq`=1, `ManDir`=1, three Tick edges, dropping `ManReq` after the ack → `ManAck` once, `Up`=1 for exactly one slot, then `Up`=`Down`=0.
- `AutoReq`, `AutoDir`=0, `AutoCount`=3 → `AutoAck`; `Down`=1 for 3 slots; `AutoBusy` high for 3 slots; `AutoDone` at the 4th Tick edge.
- `ManReq` and `AutoReq` (count 2) both raised at reset-exit, both held high after their acks → manual slot first, then 2 auto slots, then manual again (round-robin); no gap slots.
- `AutoCount`=5 burst, `AutoAbort` raised during slot 2 → exactly 2 down/up slots issued; `AutoDone` at the 3rd Tick edge.
- `AutoCount`=0 → one empty slot, then `AutoDone`.
- Assert `Reset` mid-burst (`Remaining`=2) → outputs 0 immediately, no `AutoDone`; a fresh `AutoReq` after release starts cleanly.
- All scenarios: assertion that `Up & Down` never equals 1.
